// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: issues imem requests (one outstanding), applies
// delayed-branch redirects, and presents instructions through an output register plus skid.
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        f_valid,
   output logic [31:0] f_pc,
   output logic [31:0] f_instr,
   output logic        f_adel
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t            state;
   logic [XLEN-1:0]   req_addr;
   logic              req_adel;
   logic              req_redir;
   logic [XLEN-1:0]   fly_addr;
   logic              fly_adel;
   logic [XLEN-1:0]   seq_addr;
   logic              pending;
   logic [XLEN-1:0]   slot;
   logic [XLEN-1:0]   pend_addr;
   logic              pend_adel;
   logic              skid_valid;
   logic [XLEN-1:0]   skid_pc;
   logic [XLEN-1:0]   skid_instr;
   logic              skid_adel;

   logic              consume;
   logic              issue_ok;
   logic              cur_pending;
   logic [XLEN-1:0]   cur_slot;
   logic [XLEN-1:0]   cur_target;
   logic              cur_tadel;
   logic              use_redir;
   logic [XLEN-1:0]   next_addr;
   logic              next_adel;
   logic              issue_now;
   logic              sel_adel;
   logic              sel_redir;
   logic              granted;
   logic              load_out;

   assign consume  = f_valid && !stall;
   assign issue_ok = !skid_valid && !(f_valid && stall);

   // A redirect arriving this cycle takes effect immediately for the slot request.
   assign cur_pending = pending || redirect_valid;
   assign cur_slot    = redirect_valid ? f_pc + XLEN'(8) : slot;
   assign cur_target  = redirect_valid ? {redirect_target[31:2], 2'b00} : pend_addr;
   assign cur_tadel   = redirect_valid ? (redirect_target[1:0] != 2'b00) : pend_adel;
   assign use_redir   = cur_pending && (seq_addr == cur_slot);
   assign next_addr   = use_redir ? cur_target : seq_addr;
   assign next_adel   = use_redir && cur_tadel;

   // Back-to-back issue: a new request goes out in the cycle its predecessor returns.
   assign issue_now = (state == S_WAIT) && imem_rvalid && issue_ok;
   assign imem_req  = (state == S_REQ) || issue_now;
   assign imem_addr = issue_now ? next_addr : req_addr;
   assign sel_adel  = issue_now ? next_adel : req_adel;
   assign sel_redir = issue_now ? use_redir : req_redir;
   assign granted   = imem_req && imem_gnt;
   assign load_out  = !f_valid || consume;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         req_addr   <= RESET_PC;
         req_adel   <= 1'b0;
         req_redir  <= 1'b0;
         fly_addr   <= RESET_PC;
         fly_adel   <= 1'b0;
         seq_addr   <= RESET_PC;
         pending    <= 1'b0;
         slot       <= '0;
         pend_addr  <= '0;
         pend_adel  <= 1'b0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= '0;
         skid_adel  <= 1'b0;
         f_valid    <= 1'b0;
         f_pc       <= RESET_PC;
         f_instr    <= '0;
         f_adel     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue_ok) begin
                  state     <= S_REQ;
                  req_addr  <= next_addr;
                  req_adel  <= next_adel;
                  req_redir <= use_redir;
               end
            end
            S_REQ: begin
               if (imem_gnt) state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (!issue_ok) begin
                     state <= S_IDLE;
                  end else if (!imem_gnt) begin
                     state     <= S_REQ;
                     req_addr  <= next_addr;
                     req_adel  <= next_adel;
                     req_redir <= use_redir;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase

         // Tag the in-flight request and advance the sequential stream.
         if (granted) begin
            seq_addr <= imem_addr + XLEN'(4);
            fly_addr <= imem_addr;
            fly_adel <= sel_adel;
         end

         if (granted && sel_redir) begin
            pending <= 1'b0;
         end else if (redirect_valid) begin
            pending   <= 1'b1;
            slot      <= cur_slot;
            pend_addr <= cur_target;
            pend_adel <= cur_tadel;
         end

         // Output register refill: skid first, then a fresh response.
         if (load_out) begin
            if (skid_valid) begin
               f_valid    <= 1'b1;
               f_pc       <= skid_pc;
               f_instr    <= skid_instr;
               f_adel     <= skid_adel;
               skid_valid <= 1'b0;
            end else if (imem_rvalid) begin
               f_valid <= 1'b1;
               f_pc    <= fly_addr;
               f_instr <= imem_rdata;
               f_adel  <= fly_adel;
            end else begin
               f_valid <= 1'b0;
            end
         end

         if (imem_rvalid && !(load_out && !skid_valid)) begin
            skid_valid <= 1'b1;
            skid_pc    <= fly_addr;
            skid_instr <= imem_rdata;
            skid_adel  <= fly_adel;
         end
      end
   end

endmodule
